inst_fetch_queue: RTL

//  Decoupling queue between fetch (PC + InstMem read) and decode (ID).

---
 rtl/inst_fetch_queue_pkg.sv | 14 +
 rtl/inst_fetch_queue_if.sv | 29 ++
 rtl/fetch_queue_ram.sv | 26 ++
 rtl/inst_fetch_queue.sv | 79 +++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared fetch-side constants: default widths, NOP encoding, enable levels.
package inst_fetch_queue_pkg;

    localparam int PC_WIDTH_DEF   = 32;
    localparam int INST_WIDTH_DEF = 32;
    localparam int DEPTH_DEF      = 4;
    localparam int PTR_W_DEF      = 2;

    localparam logic [31:0] NOP_INST = 32'h0;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode queue bundle; master is the fetch/ID side, slave is the queue.
interface inst_fetch_queue_if #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32,
    parameter int PTR_W      = 2
);

    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
    logic                  romCe;
    logic                  flush;
    logic                  stallId;
    logic                  full;
    logic                  idValid;
    logic [PC_WIDTH-1:0]   idPc;
    logic [INST_WIDTH-1:0] idInst;
    logic [PTR_W:0]        count;

    modport master (
        output pc, inst, romCe, flush, stallId,
        input  full, idValid, idPc, idInst, count
    );

    modport slave (
        input  pc, inst, romCe, flush, stallId,
        output full, idValid, idPc, idInst, count
    );

endinterface

// File: rtl/fetch_queue_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one async read port.
// No reset; readers must qualify the read data with their own occupancy.
module fetch_queue_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdat,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdat
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Circular FIFO of {pc, inst} pairs between fetch and decode; head shown after 1 edge.
// full (from registered count) holds fetch; stallId holds the head; flush empties the queue.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int PC_WIDTH   = PC_WIDTH_DEF,
    parameter int INST_WIDTH = INST_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int PTR_W      = PTR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    inst_fetch_queue_if.slave io_fq
);

    localparam int             ENTRY_W = PC_WIDTH + INST_WIDTH;
    localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    logic               w_full;
    logic               w_valid;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_rd_dat;

    assign w_full  = (r_count == C_DEPTH) ? ENABLE : DISABLE;
    assign w_valid = (r_count != '0) ? ENABLE : DISABLE;
    assign w_push  = io_fq.romCe & ~w_full & ~io_fq.flush;
    assign w_pop   = w_valid & ~io_fq.stallId & ~io_fq.flush;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (io_fq.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    fetch_queue_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdat  ({io_fq.pc, io_fq.inst}),
        .i_raddr (r_rd_ptr),
        .o_rdat  (w_rd_dat)
    );

    // Gate the head so stale storage never leaks out when empty.
    assign io_fq.idPc    = w_valid ? w_rd_dat[ENTRY_W-1:INST_WIDTH] : '0;
    assign io_fq.idInst  = w_valid ? w_rd_dat[INST_WIDTH-1:0] : INST_WIDTH'(NOP_INST);
    assign io_fq.idValid = w_valid;
    assign io_fq.full    = w_full;
    assign io_fq.count   = r_count;

endmodule
